// File: rtl/delay_arb_pkg.sv
// delay_arb_pkg: shared definitions for the delay arbiter slice.
//   state_e      - arbiter FSM state encoding (StIdle=0, StCount=1, StDone=2)
//   US_PER_S     - microseconds per second
//   ticks_per_us - clk cycles per microsecond, never less than one
package delay_arb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCount = 2'd1,
    StDone  = 2'd2
  } state_e;

  localparam int unsigned US_PER_S = 1000000;

  // Clocks slower than 1 MHz still count one cycle per microsecond.
  function automatic int unsigned ticks_per_us(input int unsigned clk_freq);
    return (clk_freq < US_PER_S) ? 1 : clk_freq / US_PER_S;
  endfunction

endpackage

// File: rtl/us_tick_gen.sv
// us_tick_gen: microsecond strobe generator.
// Emits a one-cycle tick every TICKS_PER_US cycles while en is high. The phase
// counter is held at zero while disabled, so the first tick after en rises
// lands exactly TICKS_PER_US cycles after the rise.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-low reset
//   en   - count enable
//   tick - one-cycle pulse at the end of each microsecond
module us_tick_gen #(
  parameter int unsigned TICKS_PER_US = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned PhaseW = $clog2(TICKS_PER_US + 1);
  localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(TICKS_PER_US - 1);

  logic [PhaseW-1:0] phase_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= '0;
    end else if (!en || phase_q == PhaseLast) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_q + 1'b1;
    end
  end

  assign tick = en && (phase_q == PhaseLast);

endmodule

// File: rtl/delay_arbiter.sv
// delay_arbiter: round-robin arbiter sharing one microsecond delay timer.
// A requester holds req[i] until its done[i] pulse; the winner owns the timer
// (grant[i] high) for max(1, req_us_i * ticks-per-us) cycles, then done[i]
// pulses for one cycle with grant low. Dropping req during the delay cancels
// it without a done pulse.
// Optional build macro: DELAY_ABORT_EN adds the abort input.
// Ports:
//   clk    - clock
//   rst    - asynchronous active-low reset
//   req    - level request per requester
//   req_us - per-requester delay in us, slice i at [i*CNT_W +: CNT_W]
//   abort  - cancel the active delay (DELAY_ABORT_EN only)
//   grant  - one-hot owner of the timer
//   done   - one-cycle expiry pulse per requester
//   busy   - FSM not idle
module delay_arbiter
  import delay_arb_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 12000000,
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned CNT_W    = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] req_us,
`ifdef DELAY_ABORT_EN
  input  logic                     abort,
`endif
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy
);

  localparam int unsigned TicksPerUs = ticks_per_us(CLK_FREQ);
  localparam int unsigned IdxW       = $clog2(NUM_REQ);

  state_e             state_q;
  logic [IdxW-1:0]    idx_q;
  logic [IdxW-1:0]    last_q;
  logic [IdxW-1:0]    pick;
  logic [CNT_W-1:0]   us_left_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] done_q;
  logic               tick;
  logic               expire;
  logic               stop;

  us_tick_gen #(
    .TICKS_PER_US(TicksPerUs)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (state_q == StCount),
    .tick(tick)
  );

  // Scan downward so the nearest requester after last_q overwrites the rest.
  always_comb begin
    pick = last_q;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[IdxW'((32'(last_q) + 32'(k)) % NUM_REQ)]) begin
        pick = IdxW'((32'(last_q) + 32'(k)) % NUM_REQ);
      end
    end
  end

  // A zero-us delay expires in the first count cycle.
  assign expire = (us_left_q == '0) || (tick && us_left_q == CNT_W'(1));

`ifdef DELAY_ABORT_EN
  assign stop = !req[idx_q] || abort;
`else
  assign stop = !req[idx_q];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      last_q    <= IdxW'(NUM_REQ - 1);
      us_left_q <= '0;
      grant_q   <= '0;
      done_q    <= '0;
    end else begin
      done_q <= '0;
      case (state_q)
        StIdle: begin
          if (|req) begin
            state_q   <= StCount;
            idx_q     <= pick;
            grant_q   <= NUM_REQ'(1) << pick;
            us_left_q <= req_us[32'(pick) * CNT_W +: CNT_W];
          end
        end
        StCount: begin
          if (stop) begin
            state_q <= StIdle;
            grant_q <= '0;
            last_q  <= idx_q;
          end else if (expire) begin
            state_q        <= StDone;
            grant_q        <= '0;
            done_q[idx_q]  <= 1'b1;
            last_q         <= idx_q;
          end else if (tick) begin
            us_left_q <= us_left_q - 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          grant_q <= '0;
        end
      endcase
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = (state_q != StIdle);

endmodule
